// File: rtl/prog_loader_pkg.sv
// Shared types and stream-format constants for the program loader.
package prog_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StHi,
    StLo,
    StWrite,
    StDone,
    StErr
  } state_e;

  // Stream format: one header byte holding (word count - 1), then each word
  // as two bytes with the high byte sent first.
  localparam int unsigned ByteW        = 8;
  localparam int unsigned BytesPerWord = 2;
  localparam int unsigned HdrBias      = 1;
  localparam bit          HiByteFirst  = 1'b1;

  // Idle budget between bytes once a load has started (0 disables it).
  localparam int unsigned DefaultTimeout = 1000000;
  localparam int unsigned DefaultTmoW    = 20;

  // Combine two stream bytes, in arrival order, into an instruction word.
  function automatic logic [BytesPerWord*ByteW-1:0] assemble_word(
    input logic [ByteW-1:0] first,
    input logic [ByteW-1:0] second
  );
    return HiByteFirst ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the loader: cleared by clr, counts while en is high
// and flags expiry once it reaches TIMEOUT-1. TIMEOUT of 0 never expires.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned TMO_W   = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] Limit = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Expiry only matters while a load is active.
  always_comb begin
    expired = (TIMEOUT != 0) && en && (cnt_q == Limit);
  end

  // Next count: clear wins, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot/program-load controller: assembles a byte stream into 16-bit words,
// writes them to instruction memory from address 0 and holds the CPU until
// the load completes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned TMO_W   = DefaultTmoW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_data,
  output logic              im_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_e state_q, state_d;

  logic              byte_ready_q, byte_ready_d;
  logic              im_we_q, im_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [DATA_W-1:0] im_data_q;
  logic [ADDR_W:0]   words_q;

  logic accept;
  logic tmo_clr;
  logic tmo_en;
  logic expired;

  assign accept = byte_valid && byte_ready_q;

  // Counter is parked at zero outside a load and restarts on every accepted
  // byte. It also runs through WRITE so the budget spans accept to accept.
  assign tmo_clr = accept || (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
  assign tmo_en  = (state_q == StHdr) || (state_q == StHi) || (state_q == StLo) ||
                   (state_q == StWrite);

  loader_timeout #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (expired)
  );

  // State and registered-output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next-state logic; an accept in the expiry cycle takes priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StHdr;
      end
      StHdr: begin
        if (accept)       state_d = StHi;
        else if (expired) state_d = StErr;
      end
      StHi: begin
        if (accept)       state_d = StLo;
        else if (expired) state_d = StErr;
      end
      StLo: begin
        if (accept)       state_d = StWrite;
        else if (expired) state_d = StErr;
      end
      StWrite: begin
        state_d = (idx_q == cnt_q) ? StDone : StHi;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state, so outputs are registered with it.
  always_comb begin
    byte_ready_d = 1'b0;
    im_we_d      = 1'b0;
    cpu_hold_d   = 1'b1;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    unique case (state_d)
      StHdr, StHi, StLo: begin
        byte_ready_d = 1'b1;
        busy_d       = 1'b1;
      end
      StWrite: begin
        im_we_d = 1'b1;
        busy_d  = 1'b1;
      end
      StDone: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      StErr: begin
        error_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Word assembly, address generation and word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      hi_q      <= '0;
      im_addr_q <= '0;
      im_data_q <= '0;
      words_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) words_q <= '0;
        end
        StHdr: begin
          if (accept) begin
            cnt_q <= ADDR_W'(byte_in);
            idx_q <= '0;
          end
        end
        StHi: begin
          if (accept) hi_q <= byte_in;
        end
        StLo: begin
          if (accept) begin
            im_data_q <= DATA_W'(assemble_word(hi_q, byte_in));
            im_addr_q <= idx_q;
          end
        end
        StWrite: begin
          words_q <= (ADDR_W + 1)'(idx_q) + (ADDR_W + 1)'(1);
          // Final word leaves idx at the last address, so N=256 never wraps.
          if (idx_q != cnt_q) idx_q <= idx_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign byte_ready   = byte_ready_q;
  assign im_we        = im_we_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign im_addr      = im_addr_q;
  assign im_data      = im_data_q;
  assign words_loaded = words_q;

endmodule
